// File: rtl/cci_mpf_shim_tx_buffer.sv
// Elastic Tx request buffer ahead of MPF-to-QLP canonicalization: one FIFO per channel,
// registered output, almost-full regenerated from occupancy. Optional macro: CCI_MPF_TX_BUFFER_BYPASS_EN.

module cci_mpf_shim_tx_buffer_chan #(
  parameter int DATA_W        = 128,
  parameter int DEPTH         = 16,
  parameter int ALMFULL_SLACK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              afu_tx_valid,
  input  logic [DATA_W-1:0] afu_tx,
  output logic              afu_tx_almfull,
  output logic              qlp_tx_valid,
  output logic [DATA_W-1:0] qlp_tx,
  input  logic              qlp_tx_almfull,
  output logic              overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] ALMFULL_TH = CW'(DEPTH - ALMFULL_SLACK);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_p0, rd_ptr_p0;
  logic [CW-1:0]     cnt_p0, cnt_nxt;
  logic              pop, push, drop, byp, full;

  logic              vld_p1, almfull_p1, overflow_p1;
  logic [DATA_W-1:0] data_p1;

  always_comb begin
    full = (cnt_p0 == FULL_CNT);
    pop  = (cnt_p0 != '0) && !qlp_tx_almfull;
`ifdef CCI_MPF_TX_BUFFER_BYPASS_EN
    // An empty FIFO with an open downstream lets the request skip storage entirely.
    byp  = (cnt_p0 == '0) && !qlp_tx_almfull && afu_tx_valid;
`else
    byp  = 1'b0;
`endif
    push    = afu_tx_valid && !byp && (!full || pop);
    drop    = afu_tx_valid && full && !pop;
    cnt_nxt = cnt_p0 + CW'(push) - CW'(pop);
  end

  // Stage p0: FIFO pointers, occupancy and storage
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      cnt_p0    <= '0;
    end else begin
      if (push) wr_ptr_p0 <= wr_ptr_p0 + AW'(1);
      if (pop)  rd_ptr_p0 <= rd_ptr_p0 + AW'(1);
      cnt_p0 <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_p0] <= afu_tx;
  end

  // Stage p1: registered output toward QLP and flags toward the AFU
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      almfull_p1  <= 1'b0;
      overflow_p1 <= 1'b0;
    end else begin
      vld_p1     <= pop || byp;
      almfull_p1 <= (cnt_nxt >= ALMFULL_TH);
      if (drop) overflow_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop || byp) data_p1 <= byp ? afu_tx : mem[rd_ptr_p0];
  end

  assign qlp_tx_valid   = vld_p1;
  assign qlp_tx         = data_p1;
  assign afu_tx_almfull = almfull_p1;
  assign overflow       = overflow_p1;
endmodule

module cci_mpf_shim_tx_buffer #(
  parameter int C0_REQ_WIDTH  = 128,
  parameter int C1_REQ_WIDTH  = 640,
  parameter int DEPTH         = 16,
  parameter int ALMFULL_SLACK = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    afu_c0_tx_valid,
  input  logic [C0_REQ_WIDTH-1:0] afu_c0_tx,
  output logic                    afu_c0_tx_almfull,
  input  logic                    afu_c1_tx_valid,
  input  logic [C1_REQ_WIDTH-1:0] afu_c1_tx,
  output logic                    afu_c1_tx_almfull,
  output logic                    qlp_c0_tx_valid,
  output logic [C0_REQ_WIDTH-1:0] qlp_c0_tx,
  input  logic                    qlp_c0_tx_almfull,
  output logic                    qlp_c1_tx_valid,
  output logic [C1_REQ_WIDTH-1:0] qlp_c1_tx,
  input  logic                    qlp_c1_tx_almfull,
  output logic                    c0_overflow,
  output logic                    c1_overflow
);
  cci_mpf_shim_tx_buffer_chan #(
    .DATA_W(C0_REQ_WIDTH), .DEPTH(DEPTH), .ALMFULL_SLACK(ALMFULL_SLACK)
  ) u_c0 (
    .clk(clk), .reset(reset),
    .afu_tx_valid(afu_c0_tx_valid), .afu_tx(afu_c0_tx), .afu_tx_almfull(afu_c0_tx_almfull),
    .qlp_tx_valid(qlp_c0_tx_valid), .qlp_tx(qlp_c0_tx), .qlp_tx_almfull(qlp_c0_tx_almfull),
    .overflow(c0_overflow)
  );

  cci_mpf_shim_tx_buffer_chan #(
    .DATA_W(C1_REQ_WIDTH), .DEPTH(DEPTH), .ALMFULL_SLACK(ALMFULL_SLACK)
  ) u_c1 (
    .clk(clk), .reset(reset),
    .afu_tx_valid(afu_c1_tx_valid), .afu_tx(afu_c1_tx), .afu_tx_almfull(afu_c1_tx_almfull),
    .qlp_tx_valid(qlp_c1_tx_valid), .qlp_tx(qlp_c1_tx), .qlp_tx_almfull(qlp_c1_tx_almfull),
    .overflow(c1_overflow)
  );
endmodule

// File: tb/tb_cci_mpf_shim_tx_buffer.sv
// Scoreboard bench for cci_mpf_shim_tx_buffer (DEPTH=16, ALMFULL_SLACK=4); honours CCI_MPF_TX_BUFFER_BYPASS_EN.
module tb_cci_mpf_shim_tx_buffer;
  logic         clk = 1'b0;
  logic         reset;
  logic         afu_c0_tx_valid, afu_c1_tx_valid;
  logic [127:0] afu_c0_tx;
  logic [639:0] afu_c1_tx;
  logic         afu_c0_tx_almfull, afu_c1_tx_almfull;
  logic         qlp_c0_tx_valid, qlp_c1_tx_valid;
  logic [127:0] qlp_c0_tx;
  logic [639:0] qlp_c1_tx;
  logic         qlp_c0_tx_almfull, qlp_c1_tx_almfull;
  logic         c0_overflow, c1_overflow;

  int tests = 0;
  int fails = 0;
  int c0_seen = 0;
  logic [127:0] exp_c0 [$];
  logic [639:0] exp_c1 [$];

  always #5 clk = ~clk;

  cci_mpf_shim_tx_buffer dut (
    .clk(clk), .reset(reset),
    .afu_c0_tx_valid(afu_c0_tx_valid), .afu_c0_tx(afu_c0_tx), .afu_c0_tx_almfull(afu_c0_tx_almfull),
    .afu_c1_tx_valid(afu_c1_tx_valid), .afu_c1_tx(afu_c1_tx), .afu_c1_tx_almfull(afu_c1_tx_almfull),
    .qlp_c0_tx_valid(qlp_c0_tx_valid), .qlp_c0_tx(qlp_c0_tx), .qlp_c0_tx_almfull(qlp_c0_tx_almfull),
    .qlp_c1_tx_valid(qlp_c1_tx_valid), .qlp_c1_tx(qlp_c1_tx), .qlp_c1_tx_almfull(qlp_c1_tx_almfull),
    .c0_overflow(c0_overflow), .c1_overflow(c1_overflow)
  );

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output beat is matched against the head of its channel's expectation queue.
  always @(negedge clk) begin
    if (qlp_c0_tx_valid) begin
      c0_seen++;
      if (exp_c0.size() == 0) check("c0_unexpected_beat", 640'(qlp_c0_tx), 640'(0));
      else check("c0_data", 640'(qlp_c0_tx), 640'(exp_c0.pop_front()));
    end
    if (qlp_c1_tx_valid) begin
      if (exp_c1.size() == 0) check("c1_unexpected_beat", qlp_c1_tx, 640'(0));
      else check("c1_data", qlp_c1_tx, exp_c1.pop_front());
    end
  end

  initial begin
    logic [127:0] d0;
    logic [639:0] d1;
    reset = 1'b1;
    afu_c0_tx_valid = 1'b0; afu_c1_tx_valid = 1'b0;
    afu_c0_tx = '0; afu_c1_tx = '0;
    qlp_c0_tx_almfull = 1'b0; qlp_c1_tx_almfull = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_c0_valid", 640'(qlp_c0_tx_valid), 640'(0));
    check("rst_c1_valid", 640'(qlp_c1_tx_valid), 640'(0));
    check("rst_c0_almfull", 640'(afu_c0_tx_almfull), 640'(0));
    check("rst_c1_almfull", 640'(afu_c1_tx_almfull), 640'(0));
    check("rst_c0_overflow", 640'(c0_overflow), 640'(0));
    check("rst_c1_overflow", 640'(c1_overflow), 640'(0));
    reset = 1'b0;
    tick();

    // Single c0 request, latency check
    afu_c0_tx_valid = 1'b1; afu_c0_tx = 128'h1234; exp_c0.push_back(128'h1234);
    tick();
    afu_c0_tx_valid = 1'b0;
    @(negedge clk);
`ifdef CCI_MPF_TX_BUFFER_BYPASS_EN
    check("t1_valid_n1", 640'(qlp_c0_tx_valid), 640'(1));
`else
    check("t1_valid_n1", 640'(qlp_c0_tx_valid), 640'(0));
`endif
    tick();
    @(negedge clk);
`ifdef CCI_MPF_TX_BUFFER_BYPASS_EN
    check("t1_valid_n2", 640'(qlp_c0_tx_valid), 640'(0));
`else
    check("t1_valid_n2", 640'(qlp_c0_tx_valid), 640'(1));
`endif
    check("t1_almfull", 640'(afu_c0_tx_almfull), 640'(0));
    repeat (3) tick();

    // c1: 12 pushes under downstream almfull, then drain
    @(negedge clk);
    qlp_c1_tx_almfull = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d1 = {20{32'hC100_0000 + 32'(i)}};
      afu_c1_tx_valid = 1'b1; afu_c1_tx = d1; exp_c1.push_back(d1);
      tick();
      @(negedge clk);
      check($sformatf("t2_almfull_%0d", i), 640'(afu_c1_tx_almfull), 640'(i >= 11));
      check($sformatf("t2_noval_%0d", i), 640'(qlp_c1_tx_valid), 640'(0));
    end
    afu_c1_tx_valid = 1'b0;
    qlp_c1_tx_almfull = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      check($sformatf("t2_drain_vld_%0d", i), 640'(qlp_c1_tx_valid), 640'(1));
      if (i == 0) check("t2_almfull_fall", 640'(afu_c1_tx_almfull), 640'(0));
    end
    tick();
    @(negedge clk);
    check("t2_drain_end", 640'(qlp_c1_tx_valid), 640'(0));
    check("t2_queue_empty", 640'(exp_c1.size()), 640'(0));

    // c0: fill to 16, push+pop at full, then one dropped request
    qlp_c0_tx_almfull = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d0 = 128'hA000 + 128'(i);
      afu_c0_tx_valid = 1'b1; afu_c0_tx = d0; exp_c0.push_back(d0);
      tick();
    end
    afu_c0_tx_valid = 1'b0;
    @(negedge clk);
    check("t3_full_no_ovf", 640'(c0_overflow), 640'(0));
    check("t3_full_almfull", 640'(afu_c0_tx_almfull), 640'(1));
    qlp_c0_tx_almfull = 1'b0;
    afu_c0_tx_valid = 1'b1; afu_c0_tx = 128'hBEEF; exp_c0.push_back(128'hBEEF);
    tick();
    qlp_c0_tx_almfull = 1'b1;
    afu_c0_tx_valid = 1'b0;
    @(negedge clk);
    check("t4_pushpop_no_ovf", 640'(c0_overflow), 640'(0));
    check("t4_pushpop_vld", 640'(qlp_c0_tx_valid), 640'(1));
    afu_c0_tx_valid = 1'b1; afu_c0_tx = 128'hDEAD;
    tick();
    afu_c0_tx_valid = 1'b0;
    tick();
    @(negedge clk);
    check("t3_ovf_set", 640'(c0_overflow), 640'(1));
    qlp_c0_tx_almfull = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    check("t3_ovf_sticky", 640'(c0_overflow), 640'(1));
    check("t3_queue_empty", 640'(exp_c0.size()), 640'(0));

    // Interleaved traffic, c1 downstream almfull toggling every 3 cycles
    c0_seen = 0;
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) qlp_c1_tx_almfull = ~qlp_c1_tx_almfull;
      d0 = 128'h5000 + 128'(i);
      d1 = {20{32'h6600_0000 + 32'(i)}};
      afu_c0_tx_valid = 1'b1; afu_c0_tx = d0; exp_c0.push_back(d0);
      afu_c1_tx_valid = 1'b1; afu_c1_tx = d1; exp_c1.push_back(d1);
      tick();
    end
    afu_c0_tx_valid = 1'b0; afu_c1_tx_valid = 1'b0;
    qlp_c1_tx_almfull = 1'b0;
    repeat (24) tick();
    @(negedge clk);
    check("t5_c0_count", 640'(c0_seen), 640'(24));
    check("t5_c0_empty", 640'(exp_c0.size()), 640'(0));
    check("t5_c1_empty", 640'(exp_c1.size()), 640'(0));
    check("t5_c1_no_ovf", 640'(c1_overflow), 640'(0));

    // Reset with 8 buffered c0 entries and a valid output; only the head escapes first
    qlp_c0_tx_almfull = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d0 = 128'h7700 + 128'(i);
      afu_c0_tx_valid = 1'b1; afu_c0_tx = d0;
      if (i == 0) exp_c0.push_back(d0);
      tick();
    end
    afu_c0_tx_valid = 1'b0;
    @(negedge clk);
    qlp_c0_tx_almfull = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("t6_pre_vld", 640'(qlp_c0_tx_valid), 640'(1));
    tick();
    @(negedge clk);
    check("t6_c0_valid", 640'(qlp_c0_tx_valid), 640'(0));
    check("t6_c1_valid", 640'(qlp_c1_tx_valid), 640'(0));
    check("t6_c0_almfull", 640'(afu_c0_tx_almfull), 640'(0));
    check("t6_c1_almfull", 640'(afu_c1_tx_almfull), 640'(0));
    check("t6_c0_overflow", 640'(c0_overflow), 640'(0));
    check("t6_c1_overflow", 640'(c1_overflow), 640'(0));
    reset = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    check("t6_c0_empty", 640'(exp_c0.size()), 640'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
